// File: rtl/uart_rx_core.sv
// UART receiver core: 16x oversampled 8N1 receiver with a single-entry
// holding register and a valid/ready handshake on the byte output.
module uart_rx_core #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  output logic [7:0] RxData,
  output logic       valid_rx,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic        rxd_meta_q, rxd_sync_q;
  logic [CW-1:0] tick_cnt_q;
  logic [3:0]  samp_cnt_q;
  logic [2:0]  bit_idx_q;
  logic [2:0]  smp_q;          // samples taken at counts 7, 8, 9
  logic [7:0]  shift_q;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;

  logic        tick;
  logic        maj_buf, maj_stop;
  logic        start_det, bit_end, deliver, frame_bad;

  assign tick     = (tick_cnt_q == DIV_LAST);
  assign maj_buf  = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
  // The stop decision happens on the count-9 tick itself, so the third
  // sample is the live synchronized line rather than the stored copy.
  assign maj_stop = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxd_sync_q) | (smp_q[1] & rxd_sync_q);

  // Next-state logic and output-stage decisions.
  always_comb begin
    state_d   = state_q;
    start_det = 1'b0;
    bit_end   = 1'b0;
    deliver   = 1'b0;
    frame_bad = 1'b0;
    rx_data_d = rx_data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rxd_sync_q) begin
          state_d   = START;
          start_det = 1'b1;
        end
      end
      START: begin
        if (tick && samp_cnt_q == 4'd15) begin
          state_d = maj_buf ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick && samp_cnt_q == 4'd15) begin
          bit_end = 1'b1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tick && samp_cnt_q == 4'd9) begin
          state_d = IDLE;
          if (maj_stop) deliver = 1'b1;
          else          frame_bad = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A consumer transfer frees the holding register this cycle.
    if (valid_q && rx_ready) valid_d = 1'b0;

    if (deliver) begin
      if (!valid_q || rx_ready) begin
        rx_data_d = shift_q;
        valid_d   = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
    ferr_d = frame_bad;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Two-flop synchronizer for the asynchronous serial line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
    end else begin
      rxd_meta_q <= RxD;
      rxd_sync_q <= rxd_meta_q;
    end
  end

  // Oversample tick divider and sample counter, realigned at each start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
      samp_cnt_q <= 4'd0;
    end else if (start_det) begin
      tick_cnt_q <= '0;
      samp_cnt_q <= 4'd0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + CW'(1);
      if (tick && state_q != IDLE) samp_cnt_q <= samp_cnt_q + 4'd1;
    end
  end

  // Mid-bit samples, bit index and LSB-first shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      smp_q     <= 3'b000;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
    end else begin
      if (tick && state_q != IDLE) begin
        case (samp_cnt_q)
          4'd7:    smp_q[0] <= rxd_sync_q;
          4'd8:    smp_q[1] <= rxd_sync_q;
          4'd9:    smp_q[2] <= rxd_sync_q;
          default: ;
        endcase
      end
      if (state_q == START)  bit_idx_q <= 3'd0;
      else if (bit_end)      bit_idx_q <= bit_idx_q + 3'd1;
      if (bit_end) shift_q <= {maj_buf, shift_q[7:1]};
    end
  end

  // Holding register and one-cycle status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data_q <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_data_q <= rx_data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign RxData    = rx_data_q;
  assign valid_rx  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus a short
// randomized run checked against a transaction-level holding-register model.
module tb_uart_rx_core;

  localparam int BIT = 432;   // clk per bit at 50 MHz / 115200 with 16x oversampling

  logic       clk = 1'b0;
  logic       reset;
  logic       RxD;
  logic [7:0] RxData;
  logic       valid_rx;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx_core #(.CLK_FREQ(50_000_000), .BAUD(115200)) dut (
    .clk       (clk),
    .reset     (reset),
    .RxD       (RxD),
    .RxData    (RxData),
    .valid_rx  (valid_rx),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  int tests = 0;
  int fails = 0;

  // Passive monitor: records every handshake transfer and status pulse.
  logic [7:0] got_mem [0:1023];
  int   got_n     = 0;
  int   valid_cyc = 0;
  int   ferr_ev   = 0;
  int   ferr_cyc  = 0;
  int   ovr_ev    = 0;
  int   ovr_cyc   = 0;
  int   both_cyc  = 0;
  logic ferr_prev = 1'b0;
  logic ovr_prev  = 1'b0;

  always @(negedge clk) begin
    if (valid_rx === 1'b1 && rx_ready === 1'b1) begin
      got_mem[got_n] = RxData;
      got_n++;
    end
    if (valid_rx === 1'b1) valid_cyc++;
    if (frame_err === 1'b1) begin
      ferr_cyc++;
      if (ferr_prev !== 1'b1) ferr_ev++;
    end
    if (overrun === 1'b1) begin
      ovr_cyc++;
      if (ovr_prev !== 1'b1) ovr_ev++;
    end
    if (frame_err === 1'b1 && overrun === 1'b1) both_cyc++;
    ferr_prev = frame_err;
    ovr_prev  = overrun;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serial frame driver; starts and ends on a falling clock edge.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    RxD = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (BIT) @(negedge clk);
    end
    RxD = stop_ok;
    repeat (BIT) @(negedge clk);
    RxD = 1'b1;
    if (!stop_ok) repeat (BIT) @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rx_ready = v;
    @(negedge clk);
  endtask

  int g0, v0, f0, fc0, o0, oc0;
  task automatic snap();
    g0 = got_n; v0 = valid_cyc; f0 = ferr_ev; fc0 = ferr_cyc; o0 = ovr_ev; oc0 = ovr_cyc;
  endtask

  logic [7:0] saurav [0:5];
  logic [7:0] exp_q [$];
  logic       hv;
  logic [7:0] hb;
  logic [7:0] rb;
  bit         rok;
  int         exp_ferr, exp_ovr;

  initial begin
    saurav[0] = 8'h53; saurav[1] = 8'h41; saurav[2] = 8'h55;
    saurav[3] = 8'h52; saurav[4] = 8'h41; saurav[5] = 8'h56;
    reset = 1'b1; RxD = 1'b1; rx_ready = 1'b1;

    // Reset state, observed while reset is held
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_rxdata", RxData, 8'h00);
    chk("rst_valid", valid_rx, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    chk("rst_busy", busy, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_busy", busy, 1'b0);

    // Single frame 'S'
    snap();
    send_frame(8'h53, 1'b1);
    repeat (20) @(negedge clk);
    chk("s_count", got_n - g0, 1);
    chk("s_byte", got_mem[g0], 8'h53);
    chk("s_valid_cycles", valid_cyc - v0, 1);
    chk("s_ferr", ferr_ev - f0, 0);
    chk("s_ovr", ovr_ev - o0, 0);
    $display("[TB] frame 53 rx_ready=1 -> %0d byte(s)", got_n - g0);

    // Back-to-back "SAURAV"
    snap();
    for (int i = 0; i < 6; i++) send_frame(saurav[i], 1'b1);
    repeat (20) @(negedge clk);
    chk("saurav_count", got_n - g0, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("saurav_byte%0d", i), got_mem[g0 + i], saurav[i]);
    chk("saurav_valid_cycles", valid_cyc - v0, 6);
    chk("saurav_ferr", ferr_ev - f0, 0);
    chk("saurav_ovr", ovr_ev - o0, 0);
    $display("[TB] SAURAV back-to-back -> %0d byte(s)", got_n - g0);

    // 100-clk low glitch on the idle line
    snap();
    RxD = 1'b0;
    repeat (50) @(negedge clk);
    chk("glitch_busy_early", busy, 1'b1);
    repeat (50) @(negedge clk);
    RxD = 1'b1;
    repeat (320) @(negedge clk);
    chk("glitch_busy_late_start", busy, 1'b1);
    repeat (40) @(negedge clk);
    chk("glitch_busy_dropped", busy, 1'b0);
    chk("glitch_valid", valid_cyc - v0, 0);
    chk("glitch_ferr", ferr_ev - f0, 0);
    $display("[TB] glitch 100 clk -> busy=%0b", busy);

    // Bad stop bit on 8'hA5
    snap();
    send_frame(8'hA5, 1'b0);
    repeat (20) @(negedge clk);
    chk("ferr_events", ferr_ev - f0, 1);
    chk("ferr_width", ferr_cyc - fc0, 1);
    chk("ferr_valid", valid_cyc - v0, 0);
    chk("ferr_rxdata_kept", RxData, 8'h56);
    chk("ferr_no_ovr", ovr_ev - o0, 0);
    $display("[TB] frame A5 bad stop -> frame_err events %0d", ferr_ev - f0);

    // Overrun with consumer stalled
    snap();
    set_ready(1'b0);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (20) @(negedge clk);
    chk("ovr_valid", valid_rx, 1'b1);
    chk("ovr_rxdata", RxData, 8'h11);
    chk("ovr_events", ovr_ev - o0, 1);
    chk("ovr_width", ovr_cyc - oc0, 1);
    chk("ovr_no_ferr", ferr_ev - f0, 0);
    chk("ovr_no_transfer", got_n - g0, 0);
    set_ready(1'b1);
    @(negedge clk);
    chk("ovr_drain_valid", valid_rx, 1'b0);
    chk("ovr_drain_count", got_n - g0, 1);
    chk("ovr_drain_byte", got_mem[g0], 8'h11);
    $display("[TB] 11,22 stalled -> held %0h, overruns %0d", got_mem[g0], ovr_ev - o0);

    // Reset in the middle of data bit 4
    RxD = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RxD = i[0];
      repeat (BIT) @(negedge clk);
    end
    RxD = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    chk("midrst_busy_before", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_valid", valid_rx, 1'b0);
    chk("midrst_rxdata", RxData, 8'h00);
    RxD = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    snap();
    repeat (2 * BIT) @(negedge clk);
    chk("midrst_idle_busy", busy, 1'b0);
    send_frame(8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    chk("midrst_count", got_n - g0, 1);
    chk("midrst_byte", got_mem[g0], 8'h3C);
    chk("midrst_ferr", ferr_ev - f0, 0);
    chk("midrst_ovr", ovr_ev - o0, 0);
    $display("[TB] reset mid-frame then 3C -> %0d byte(s)", got_n - g0);

    // Randomized frames against a holding-register model
    snap();
    hv = 1'b0; hb = 8'h00; exp_ferr = 0; exp_ovr = 0;
    for (int n = 0; n < 5; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        set_ready(logic'($urandom_range(0, 1)));
        if (rx_ready && hv) begin
          exp_q.push_back(hb);
          hv = 1'b0;
        end
      end
      rb  = 8'($urandom);
      rok = ($urandom_range(0, 4) != 0);
      send_frame(rb, rok);
      if (!rok)                   exp_ferr++;
      else if (rx_ready)          exp_q.push_back(rb);
      else if (!hv) begin hv = 1'b1; hb = rb; end
      else                        exp_ovr++;
      $display("[TB] random frame %0d byte %0h stop_ok=%0b rx_ready=%0b", n, rb, rok, rx_ready);
      repeat ($urandom_range(0, 100)) @(negedge clk);
    end
    set_ready(1'b1);
    if (hv) exp_q.push_back(hb);
    repeat (10) @(negedge clk);
    chk("rand_count", got_n - g0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) chk($sformatf("rand_byte%0d", i), got_mem[g0 + i], exp_q[i]);
    chk("rand_ferr", ferr_ev - f0, exp_ferr);
    chk("rand_ovr", ovr_ev - o0, exp_ovr);
    chk("ferr_single_pulses", ferr_cyc, ferr_ev);
    chk("ovr_single_pulses", ovr_cyc, ovr_ev);
    chk("never_both", both_cyc, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line bit rate.
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port RxD  input  1  serial line, idle high, asynchronous to clk.
REQ-006 SHALL have port RxData  output  8  received byte, held stable while valid_rx=1.
REQ-007 SHALL have port valid_rx  output  1  RxData holds an unconsumed byte.
REQ-008 SHALL have port rx_ready  input  1  consumer accepts RxData this cycle when valid_rx=1.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse, completed byte dropped because holding register full.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-012 SHALL pass RxD through a 2-flop synchronizer; both flops reset to 1; all logic uses the synchronized value.
REQ-013 SHALL generate a 16x oversample tick: DIV = CLK_FREQ/(BAUD*16), integer division (27 at defaults); counter 0..DIV-1, tick is high for one clk when counter == DIV-1, then wraps to 0.
REQ-014 SHALL clear the tick counter and the 4-bit sample counter to 0 on the IDLE->START transition, so sampling aligns to the detected falling edge.
REQ-015 SHALL implement states IDLE, START, DATA, STOP; the 4-bit sample counter advances only on ticks and wraps 15->0.
REQ-016 IDLE: on any clk with synchronized RxD=0 -> START.
REQ-017 Every bit value SHALL be the 2-of-3 majority of the samples taken at sample counts 7, 8 and 9.
REQ-018 START: at the tick ending sample 15, majority 0 -> DATA with bit index 0; majority 1 -> IDLE (glitch rejected, no output, no error).
REQ-019 DATA: 8 bits LSB first, 16 ticks each; the bit index increments at each sample-15 tick; after bit 7 -> STOP.
REQ-020 STOP: decide at the tick of sample 9 and go directly to IDLE, leaving half a bit period to detect the next start bit (back-to-back frames, zero idle).
REQ-021 Stop majority 1 SHALL deliver the shift register to the output stage; stop majority 0 SHALL pulse frame_err for one cycle and discard the byte.
REQ-022 Output handshake: a transfer occurs on any clk with valid_rx=1 and rx_ready=1; valid_rx then falls next cycle unless a new byte is loaded in that same cycle.
REQ-023 Delivery with valid_rx=0: load RxData and set valid_rx on the next edge, 1 cycle after the STOP decision tick.
REQ-024 Delivery with valid_rx=1 and rx_ready=1 in the same cycle SHALL load the new byte; valid_rx stays 1; no overrun.
REQ-025 Delivery with valid_rx=1 and rx_ready=0 SHALL pulse overrun for one cycle, keep the old RxData, and drop the new byte.
REQ-026 frame_err and overrun SHALL never be asserted for the same frame; a framed-bad byte never touches RxData or valid_rx.
REQ-027 rx_ready with valid_rx=0 SHALL have no effect.

Reset
REQ-028 Asserting reset low SHALL immediately force: FSM IDLE, all counters 0, synchronizer flops 1, RxData 8'h00, valid_rx 0, frame_err 0, overrun 0, busy 0.
REQ-029 Reset mid-frame SHALL abandon the frame; after release the block waits for a new falling edge and emits no partial byte or error.
REQ-030 Operation SHALL resume on the first clk edge after reset deasserts.

Verification
REQ-031 Frame 8'h53 ('S') at 432 clk/bit, rx_ready=1 -> valid_rx one cycle, RxData=8'h53, no frame_err or overrun.
REQ-032 Six back-to-back frames "SAURAV" with zero idle gap, rx_ready=1 -> six valid_rx pulses, bytes 53 41 55 52 41 56 in order, no errors.
REQ-033 Low glitch of 100 clk on idle line -> returns to IDLE at the end of START, busy drops, no valid_rx or frame_err.
REQ-034 Frame 8'hA5 with stop bit driven low -> frame_err single pulse, valid_rx stays 0, RxData unchanged.
REQ-035 rx_ready=0, send 8'h11 then 8'h22 -> RxData=8'h11 held, valid_rx=1, overrun pulse at second delivery; then rx_ready=1 -> valid_rx falls.
REQ-036 Reset asserted at data bit 4 of a frame, released, then 8'h3C sent -> only RxData=8'h3C delivered, no errors.
